relu_maxpool: RTL and testbench

RELU_MAXPOOL -- requirements
Module: relu_maxpool

---
 rtl/conv_pkg.sv | 30 +++
 rtl/relu_max_unit.sv | 31 +++
 rtl/relu_maxpool.sv | 186 ++++++++++++++++++
 tb/tb_relu_maxpool.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the ReLU + max-pool stage of the conv pipeline.
//   pool_state_t  : sequencer states (IDLE, READ, DRAIN, WRITE, DONE)
//   ADDR_W        : width of every BRAM address bus in the pipeline
//   pooled_side() : side of the pooled feature map, floor(O_SIZE/P_SIZE)
//   window_cycles(): clock cycles spent on one pooling window
package conv_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } pool_state_t;

    // A trailing row/column that does not fill a whole window is dropped,
    // hence plain integer division.
    function automatic int pooled_side(input int o_size, input int p_size);
        return o_size / p_size;
    endfunction

    // P*P read cycles, one cycle for the last read data to return, one write.
    function automatic int window_cycles(input int p_size);
        return p_size * p_size + 2;
    endfunction

endpackage

// File: rtl/relu_max_unit.sv
// relu_max_unit
// Registered running maximum of signed samples. Because the register starts
// each window at zero, the final value is max(0, max(samples)), i.e. the
// ReLU of the window maximum.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears the accumulator
//   clear  : loads zero at the start of a window
//   valid  : sample carries real BRAM read data this cycle
//   sample : signed sample to compare
//   acc    : current running maximum
module relu_max_unit #(
    parameter int D_BIT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          valid,
    input  logic signed [D_BIT_WIDTH-1:0] sample,
    output logic signed [D_BIT_WIDTH-1:0] acc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (valid && (sample > acc)) begin
            acc <= sample;
        end
    end

endmodule

// File: rtl/relu_maxpool.sv
// relu_maxpool
// Walks every PxP window of K_CHANNELS conv feature maps (O_SIZE x O_SIZE,
// stored channel-major, row-major in the result BRAM), computes
// max(0, window max) and writes the pooled words to consecutive addresses of
// the pool BRAM starting at 0.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   pool_en            : start request, a rising edge starts a run while idle
//   pool_done          : one-cycle pulse after the last pooled word
//   result_bram_douta  : conv result read data, one cycle after the read
//   result_bram_ena    : conv result read enable
//   result_bram_addra  : conv result read address
//   pool_bram_dina     : pooled value
//   pool_bram_ena/wea  : pool BRAM write strobe (both high together)
//   pool_bram_addra    : pool BRAM write address
module relu_maxpool
    import conv_pkg::*;
#(
    parameter int D_BIT_WIDTH = 16,
    parameter int O_SIZE      = 22,
    parameter int K_CHANNELS  = 16,
    parameter int P_SIZE      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pool_en,
    output logic                          pool_done,
    input  logic signed [D_BIT_WIDTH-1:0] result_bram_douta,
    output logic                          result_bram_ena,
    output logic [ADDR_W-1:0]             result_bram_addra,
    output logic signed [D_BIT_WIDTH-1:0] pool_bram_dina,
    output logic                          pool_bram_ena,
    output logic                          pool_bram_wea,
    output logic [ADDR_W-1:0]             pool_bram_addra
);

    localparam int PO = pooled_side(O_SIZE, P_SIZE);

    localparam logic [ADDR_W-1:0] P_W       = ADDR_W'(P_SIZE);
    localparam logic [ADDR_W-1:0] O_W       = ADDR_W'(O_SIZE);
    localparam logic [ADDR_W-1:0] CH_STRIDE = ADDR_W'(O_SIZE * O_SIZE);
    localparam logic [ADDR_W-1:0] P_LAST    = ADDR_W'(P_SIZE - 1);
    localparam logic [ADDR_W-1:0] PO_LAST   = ADDR_W'(PO - 1);
    localparam logic [ADDR_W-1:0] CH_LAST   = ADDR_W'(K_CHANNELS - 1);

    pool_state_t state;
    pool_state_t next_state;

    logic                          pool_en_q;
    logic                          start_edge;
    logic                          rd_valid;
    logic [ADDR_W-1:0]             win_row;
    logic [ADDR_W-1:0]             win_col;
    logic [ADDR_W-1:0]             pcol;
    logic [ADDR_W-1:0]             prow;
    logic [ADDR_W-1:0]             ch;
    logic [ADDR_W-1:0]             wr_addr;
    logic [ADDR_W-1:0]             rd_row;
    logic [ADDR_W-1:0]             rd_col;
    logic [ADDR_W-1:0]             rd_addr;
    logic                          win_last;
    logic                          last_window;
    logic                          acc_clear;
    logic signed [D_BIT_WIDTH-1:0] acc;
    logic                          rd_active;
    logic                          wr_active;
    logic                          done_active;

    assign start_edge  = pool_en && !pool_en_q;
    assign win_last    = (win_row == P_LAST) && (win_col == P_LAST);
    assign last_window = (pcol == PO_LAST) && (prow == PO_LAST) && (ch == CH_LAST);

    // Feature-map coordinates of the current read and its flat address.
    assign rd_row  = prow * P_W + win_row;
    assign rd_col  = pcol * P_W + win_col;
    assign rd_addr = ch * CH_STRIDE + rd_row * O_W + rd_col;

    // The first read of a window clears the accumulator; the previous cycle
    // was never a read, so no sample can be lost to the clear.
    assign acc_clear = (state == READ) && (win_row == '0) && (win_col == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        rd_active   = 1'b0;
        wr_active   = 1'b0;
        done_active = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    next_state = READ;
                end
            end
            READ: begin
                rd_active = 1'b1;
                if (win_last) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_state = WRITE;
            end
            WRITE: begin
                wr_active  = 1'b1;
                next_state = last_window ? DONE : READ;
            end
            DONE: begin
                done_active = 1'b1;
                next_state  = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Window, pooled-position and write-address counters. All of them wrap
    // back to zero after the last window so the next run starts from the
    // first window without needing a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pool_en_q <= 1'b0;
            rd_valid  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            pcol      <= '0;
            prow      <= '0;
            ch        <= '0;
            wr_addr   <= '0;
        end else begin
            pool_en_q <= pool_en;
            rd_valid  <= rd_active;
            if (state == READ) begin
                if (win_col == P_LAST) begin
                    win_col <= '0;
                    win_row <= (win_row == P_LAST) ? '0 : win_row + 1'b1;
                end else begin
                    win_col <= win_col + 1'b1;
                end
            end
            if (state == WRITE) begin
                wr_addr <= last_window ? '0 : wr_addr + 1'b1;
                if (pcol == PO_LAST) begin
                    pcol <= '0;
                    if (prow == PO_LAST) begin
                        prow <= '0;
                        ch   <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                    end else begin
                        prow <= prow + 1'b1;
                    end
                end else begin
                    pcol <= pcol + 1'b1;
                end
            end
        end
    end

    relu_max_unit #(
        .D_BIT_WIDTH(D_BIT_WIDTH)
    ) u_max (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .valid (rd_valid),
        .sample(result_bram_douta),
        .acc   (acc)
    );

    // Strobes and buses are masked by rst so an abort silences the BRAM
    // ports in the very cycle reset is raised, not one cycle later.
    assign result_bram_ena   = rd_active && !rst;
    assign result_bram_addra = (rd_active && !rst) ? rd_addr : '0;
    assign pool_bram_ena     = wr_active && !rst;
    assign pool_bram_wea     = wr_active && !rst;
    assign pool_bram_addra   = (wr_active && !rst) ? wr_addr : '0;
    assign pool_bram_dina    = (wr_active && !rst) ? acc : '0;
    assign pool_done         = done_active && !rst;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool
// Directed bench for relu_maxpool: a default-size instance (22x22x16) and a
// small 5x5x1 instance, each attached to behavioural BRAM models.
module tb_relu_maxpool;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default-parameter instance.
    logic               a_rst, a_en, a_done, a_res_ena, a_pool_ena, a_pool_wea;
    logic signed [15:0] a_douta, a_dina;
    logic [15:0]        a_res_addr, a_pool_addr;

    // Small instance: O_SIZE=5, K_CHANNELS=1.
    logic               b_rst, b_en, b_done, b_res_ena, b_pool_ena, b_pool_wea;
    logic signed [15:0] b_douta, b_dina;
    logic [15:0]        b_res_addr, b_pool_addr;

    logic signed [15:0] mem_a [0:65535];
    logic signed [15:0] mem_b [0:65535];

    relu_maxpool dut_a (
        .clk              (clk),
        .rst              (a_rst),
        .pool_en          (a_en),
        .pool_done        (a_done),
        .result_bram_douta(a_douta),
        .result_bram_ena  (a_res_ena),
        .result_bram_addra(a_res_addr),
        .pool_bram_dina   (a_dina),
        .pool_bram_ena    (a_pool_ena),
        .pool_bram_wea    (a_pool_wea),
        .pool_bram_addra  (a_pool_addr)
    );

    relu_maxpool #(
        .D_BIT_WIDTH(16),
        .O_SIZE     (5),
        .K_CHANNELS (1),
        .P_SIZE     (2)
    ) dut_b (
        .clk              (clk),
        .rst              (b_rst),
        .pool_en          (b_en),
        .pool_done        (b_done),
        .result_bram_douta(b_douta),
        .result_bram_ena  (b_res_ena),
        .result_bram_addra(b_res_addr),
        .pool_bram_dina   (b_dina),
        .pool_bram_ena    (b_pool_ena),
        .pool_bram_wea    (b_pool_wea),
        .pool_bram_addra  (b_pool_addr)
    );

    // Read-port models: data appears one cycle after an enabled read.
    always @(posedge clk) begin
        if (a_res_ena) a_douta <= mem_a[a_res_addr];
        if (b_res_ena) b_douta <= mem_b[b_res_addr];
    end

    // Activity monitors, sampled mid-cycle.
    int a_wr_total = 0, a_rd_total = 0, a_done_total = 0;
    int b_wr_total = 0, b_rd_total = 0, b_done_total = 0;
    int b_bad_reads = 0, prot_err = 0;
    logic [15:0]        a_hist_addr [0:65535];
    logic signed [15:0] a_hist_data [0:65535];
    logic [15:0]        b_hist_addr [0:65535];
    logic signed [15:0] b_hist_data [0:65535];

    always @(negedge clk) begin
        if (a_pool_ena) begin
            a_hist_addr[16'(a_wr_total)] = a_pool_addr;
            a_hist_data[16'(a_wr_total)] = a_dina;
            a_wr_total++;
        end
        if (a_res_ena) a_rd_total++;
        if (a_done) a_done_total++;
        if (b_pool_ena) begin
            b_hist_addr[16'(b_wr_total)] = b_pool_addr;
            b_hist_data[16'(b_wr_total)] = b_dina;
            b_wr_total++;
        end
        if (b_res_ena) begin
            b_rd_total++;
            if ((b_res_addr % 16'd5) == 16'd4 || (b_res_addr / 16'd5) == 16'd4) b_bad_reads++;
        end
        if (b_done) b_done_total++;
        if (a_pool_wea !== a_pool_ena || b_pool_wea !== b_pool_ena) prot_err++;
        if ((a_res_ena && a_pool_ena) || (b_res_ena && b_pool_ena)) prot_err++;
        if ((a_done && (a_res_ena || a_pool_ena)) || (b_done && (b_res_ena || b_pool_ena))) prot_err++;
    end

    // Reference pooled value of window w of the default-size map.
    function automatic logic signed [15:0] exp_pool(input int w);
        int                 chn, pr, pc;
        logic signed [15:0] m, v;
        chn = w / 121;
        pr  = (w % 121) / 11;
        pc  = w % 11;
        m   = 16'sd0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                v = mem_a[16'(chn * 484 + (pr * 2 + r) * 22 + pc * 2 + c)];
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ra, input logic ea, input logic rb, input logic eb);
        a_rst = ra;
        a_en  = ea;
        b_rst = rb;
        b_en  = eb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    int cycles;
    int base;
    int rd_snap;
    int wr_snap;
    int done_snap;
    int err;
    int b_exp_data [4] = '{6, 8, 16, 18};

    initial begin
        for (int i = 0; i < 7744; i++) mem_a[i] = 16'(i % 256);
        for (int i = 0; i < 25; i++) mem_b[i] = 16'(i);
        a_douta = '0;
        b_douta = '0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        checkOutput("reset_strobes", 32'({a_done, a_res_ena, a_pool_ena, a_pool_wea}), 32'd0);
        checkOutput("reset_addrs", {a_res_addr, a_pool_addr}, 32'd0);
        checkOutput("reset_dina", 32'(a_dina), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("idle_strobes", 32'({a_done, a_res_ena, a_pool_ena, b_done, b_res_ena, b_pool_ena}), 32'd0);

        // Small map: 4 windows, trailing row/column never read.
        $display("[TB] small 5x5 run");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        cycles = 0;
        while (!b_done && cycles < 200) begin
            tick();
            cycles++;
        end
        checkOutput("b_done_latency", cycles, 25);
        repeat (5) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("b_write_count", b_wr_total, 4);
        checkOutput("b_read_count", b_rd_total, 16);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("b_addr%0d", k), 32'(b_hist_addr[16'(k)]), k);
            checkOutput($sformatf("b_data%0d", k), 32'(b_hist_data[16'(k)]), b_exp_data[k]);
        end
        checkOutput("b_edge_reads", b_bad_reads, 0);
        checkOutput("b_done_pulses", b_done_total, 1);

        // Full default run; extra edge mid-run and pool_en held after done.
        $display("[TB] full default run");
        base    = a_wr_total;
        rd_snap = a_rd_total;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        cycles = 0;
        while (!a_done && cycles < 20000) begin
            tick();
            cycles++;
            if (cycles == 3) a_en = 1'b0;
            if (cycles == 500) a_en = 1'b1;
        end
        checkOutput("a_done_latency", cycles, 16 * 121 * 6 + 1);
        repeat (40) tick();
        checkOutput("a_done_pulses", a_done_total, 1);
        checkOutput("a_write_count", a_wr_total - base, 1936);
        checkOutput("a_read_count", a_rd_total - rd_snap, 7744);
        err = 0;
        for (int k = 0; k < 1936; k++) begin
            if (a_hist_addr[16'(base + k)] !== 16'(k) || a_hist_data[16'(base + k)] !== exp_pool(k)) err++;
        end
        checkOutput("a_scoreboard_errors", err, 0);
        checkOutput("a_win0_ch0", 32'(a_hist_data[16'(base)]), 23);
        checkOutput("a_win1_ch0", 32'(a_hist_data[16'(base + 1)]), 25);
        checkOutput("a_win0_ch1", 32'(a_hist_data[16'(base + 121)]), 251);
        checkOutput("a_last_win", 32'(a_hist_data[16'(base + 1935)]), 63);
        checkOutput("a_last_addr", 32'(a_hist_addr[16'(base + 1935)]), 1935);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        // Abort with reset at the 50th write.
        $display("[TB] reset abort run");
        base = a_wr_total;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        cycles = 0;
        while ((a_wr_total - base) < 50 && cycles < 1000) begin
            tick();
            cycles++;
        end
        checkOutput("rst_reach_50", a_wr_total - base, 50);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        wr_snap   = a_wr_total;
        rd_snap   = a_rd_total;
        done_snap = a_done_total;
        tick();
        checkOutput("rst_outputs", 32'({a_done, a_res_ena, a_pool_ena, a_pool_wea}), 32'd0);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (30) tick();
        checkOutput("rst_no_writes", a_wr_total - wr_snap, 0);
        checkOutput("rst_no_reads", a_rd_total - rd_snap, 0);
        checkOutput("rst_no_done", a_done_total - done_snap, 0);

        // Restart with signed corner-case windows at the start.
        mem_a[0]  = -16'sd5;
        mem_a[1]  = -16'sd3;
        mem_a[22] = -16'sd100;
        mem_a[23] = -16'sd1;
        mem_a[2]  = -16'sd32768;
        mem_a[3]  = 16'sd32767;
        mem_a[24] = 16'sd0;
        mem_a[25] = 16'sd1;
        base = a_wr_total;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        cycles = 0;
        while ((a_wr_total - base) < 3 && cycles < 200) begin
            tick();
            cycles++;
        end
        checkOutput("restart_writes", a_wr_total - base, 3);
        checkOutput("restart_addr0", 32'(a_hist_addr[16'(base)]), 0);
        checkOutput("all_negative", 32'(a_hist_data[16'(base)]), 0);
        checkOutput("restart_addr1", 32'(a_hist_addr[16'(base + 1)]), 1);
        checkOutput("signed_extremes", 32'(a_hist_data[16'(base + 1)]), 32767);
        checkOutput("restart_data2", 32'(a_hist_data[16'(base + 2)]), 27);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        checkOutput("protocol_errors", prot_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
